// File: rtl/soc_network_adapter_fabric.sv
// -----------------------------------------------------------------------------
// soc_network_adapter_fabric
//
// NoC-side fabric of the network adapter. Each of CHANNELS physical channels
// is independent and connects MODULES endpoints to the tile router:
//   ingress: router -> FIFO -> class-routed demux -> mod_in[c][*]
//            packets whose class maps to an index >= MODULES are consumed
//            and counted in drop_count[c] (saturating, cleared by drop_clear)
//   egress : mod_out[c][*] -> packet-locked round-robin arbiter -> FIFO -> router
//
// Ports (c = channel, m = module):
//   clk, rst             clock, synchronous active-high reset
//   noc_in_*[c]          flits from router (flit/last/valid in, ready out)
//   noc_out_*[c]         flits to router (flit/last/valid out, ready in)
//   mod_in_*[c][m]       routed flits to modules (flit/last/valid out, ready in)
//   mod_out_*[c][m]      module packets for NoC (flit/last/valid in, ready out)
//   drop_count[c]        16-bit saturating dropped-packet counters
//   drop_clear           clears every drop counter (wins over an increment)
// -----------------------------------------------------------------------------

// Register-array FIFO with first-word-fall-through read port. Push is refused
// when full even if a pop happens in the same cycle, so o_full never depends
// on the consumer.
module soc_network_adapter_fabric_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rptr];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module soc_network_adapter_fabric #(
  parameter int FLIT_WIDTH  = 32,
  parameter int CHANNELS    = 2,
  parameter int MODULES     = 2,
  parameter int DEPTH       = 4,
  parameter int CLASS_LSB   = 24,
  parameter int CLASS_WIDTH = 3,
  parameter logic [(2**CLASS_WIDTH)*8-1:0] MAPPING = '1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]          noc_in_flit,
  input  logic [CHANNELS-1:0]                          noc_in_last,
  input  logic [CHANNELS-1:0]                          noc_in_valid,
  output logic [CHANNELS-1:0]                          noc_in_ready,
  output logic [CHANNELS-1:0][FLIT_WIDTH-1:0]          noc_out_flit,
  output logic [CHANNELS-1:0]                          noc_out_last,
  output logic [CHANNELS-1:0]                          noc_out_valid,
  input  logic [CHANNELS-1:0]                          noc_out_ready,
  output logic [CHANNELS-1:0][MODULES-1:0][FLIT_WIDTH-1:0] mod_in_flit,
  output logic [CHANNELS-1:0][MODULES-1:0]             mod_in_last,
  output logic [CHANNELS-1:0][MODULES-1:0]             mod_in_valid,
  input  logic [CHANNELS-1:0][MODULES-1:0]             mod_in_ready,
  input  logic [CHANNELS-1:0][MODULES-1:0][FLIT_WIDTH-1:0] mod_out_flit,
  input  logic [CHANNELS-1:0][MODULES-1:0]             mod_out_last,
  input  logic [CHANNELS-1:0][MODULES-1:0]             mod_out_valid,
  output logic [CHANNELS-1:0][MODULES-1:0]             mod_out_ready,
  output logic [CHANNELS-1:0][15:0]                    drop_count,
  input  logic                                         drop_clear
);
  localparam int MW = (MODULES > 1) ? $clog2(MODULES) : 1;
  localparam logic [7:0]    MOD_LIMIT = 8'(MODULES);
  localparam logic [MW-1:0] LAST_MOD  = MW'(MODULES - 1);

  typedef enum logic {ST_HEADER, ST_BODY}  rx_state_t;
  typedef enum logic {ST_IDLE, ST_LOCKED}  tx_state_t;

  genvar gi, gj;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      // ---------------- ingress ----------------
      logic [FLIT_WIDTH:0]    w_in_head;
      logic                   w_in_empty;
      logic                   w_in_full;
      logic                   w_in_pop;
      logic [CLASS_WIDTH-1:0] w_class;
      logic [7:0]             w_map_tgt;
      logic [7:0]             w_tgt;
      logic                   w_drop;
      logic                   w_tgt_ready;
      rx_state_t              r_rx_state;
      logic [7:0]             r_rx_tgt;
      logic                   r_rx_drop;
      logic [15:0]            r_drop_cnt;

      soc_network_adapter_fabric_fifo #(.W(FLIT_WIDTH + 1), .DEPTH(DEPTH)) u_in_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (noc_in_valid[gi]),
        .i_data  ({noc_in_last[gi], noc_in_flit[gi]}),
        .i_pop   (w_in_pop),
        .o_data  (w_in_head),
        .o_empty (w_in_empty),
        .o_full  (w_in_full)
      );

      assign noc_in_ready[gi] = !rst && !w_in_full;

      assign w_class   = w_in_head[CLASS_LSB +: CLASS_WIDTH];
      assign w_map_tgt = MAPPING[{w_class, 3'b000} +: 8];
      // Header flits are steered by their class; body flits follow the
      // decision latched when the header left the FIFO.
      assign w_tgt  = (r_rx_state == ST_BODY) ? r_rx_tgt  : w_map_tgt;
      assign w_drop = (r_rx_state == ST_BODY) ? r_rx_drop : (w_map_tgt >= MOD_LIMIT);

      always_comb begin
        w_tgt_ready = 1'b0;
        for (int m = 0; m < MODULES; m++) begin
          if (w_tgt == 8'(m)) w_tgt_ready = mod_in_ready[gi][m];
        end
      end

      // Dropped flits are consumed without waiting on any module.
      assign w_in_pop = !rst && !w_in_empty && (w_drop || w_tgt_ready);

      for (gj = 0; gj < MODULES; gj++) begin : g_mod_in
        assign mod_in_valid[gi][gj] = !rst && !w_in_empty && !w_drop && (w_tgt == 8'(gj));
        assign mod_in_flit[gi][gj]  = w_in_head[FLIT_WIDTH-1:0];
        assign mod_in_last[gi][gj]  = w_in_head[FLIT_WIDTH];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_rx_state <= ST_HEADER;
          r_rx_tgt   <= '0;
          r_rx_drop  <= 1'b0;
          r_drop_cnt <= '0;
        end else begin
          if (w_in_pop) begin
            if (w_in_head[FLIT_WIDTH]) begin
              r_rx_state <= ST_HEADER;
            end else begin
              r_rx_state <= ST_BODY;
              r_rx_tgt   <= w_tgt;
              r_rx_drop  <= w_drop;
            end
          end
          if (drop_clear) begin
            r_drop_cnt <= '0;
          end else if (w_in_pop && (r_rx_state == ST_HEADER) && w_drop &&
                       (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
          end
        end
      end

      assign drop_count[gi] = r_drop_cnt;

      // ---------------- egress ----------------
      tx_state_t           r_tx_state;
      logic [MW-1:0]       r_rr;
      logic [MW-1:0]       r_grant;
      logic [MW-1:0]       w_grant;
      logic [MW-1:0]       w_hi;
      logic [MW-1:0]       w_lo;
      logic                w_hi_found;
      logic                w_lo_found;
      logic                w_sel_valid;
      logic [FLIT_WIDTH:0] w_sel_data;
      logic                w_eg_push;
      logic                w_eg_full;
      logic                w_eg_empty;
      logic [FLIT_WIDTH:0] w_eg_head;

      // Round-robin: the lowest valid index at or above rr wins; otherwise
      // the lowest valid index below rr (wrap-around).
      always_comb begin
        w_hi       = '0;
        w_lo       = '0;
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        for (int m = 0; m < MODULES; m++) begin
          if (mod_out_valid[gi][m]) begin
            if (m >= int'(r_rr)) begin
              if (!w_hi_found) begin
                w_hi       = MW'(m);
                w_hi_found = 1'b1;
              end
            end else if (!w_lo_found) begin
              w_lo       = MW'(m);
              w_lo_found = 1'b1;
            end
          end
        end
        if (r_tx_state == ST_LOCKED) w_grant = r_grant;
        else if (w_hi_found)         w_grant = w_hi;
        else if (w_lo_found)         w_grant = w_lo;
        else                         w_grant = r_rr;
      end

      always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        for (int m = 0; m < MODULES; m++) begin
          if (w_grant == MW'(m)) begin
            w_sel_valid = mod_out_valid[gi][m];
            w_sel_data  = {mod_out_last[gi][m], mod_out_flit[gi][m]};
          end
        end
      end

      for (gj = 0; gj < MODULES; gj++) begin : g_mod_out
        assign mod_out_ready[gi][gj] = !rst && !w_eg_full && (w_grant == MW'(gj));
      end

      assign w_eg_push = !rst && w_sel_valid && !w_eg_full;

      soc_network_adapter_fabric_fifo #(.W(FLIT_WIDTH + 1), .DEPTH(DEPTH)) u_eg_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_eg_push),
        .i_data  (w_sel_data),
        .i_pop   (noc_out_valid[gi] && noc_out_ready[gi]),
        .o_data  (w_eg_head),
        .o_empty (w_eg_empty),
        .o_full  (w_eg_full)
      );

      assign noc_out_valid[gi] = !rst && !w_eg_empty;
      assign noc_out_flit[gi]  = w_eg_head[FLIT_WIDTH-1:0];
      assign noc_out_last[gi]  = w_eg_head[FLIT_WIDTH];

      // Grant stays on one module from its first flit until its last flit,
      // so packets from different modules never interleave.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_tx_state <= ST_IDLE;
          r_rr       <= '0;
          r_grant    <= '0;
        end else if (w_eg_push) begin
          if (w_sel_data[FLIT_WIDTH]) begin
            r_tx_state <= ST_IDLE;
            r_rr       <= (w_grant == LAST_MOD) ? '0 : w_grant + 1'b1;
          end else begin
            r_tx_state <= ST_LOCKED;
            r_grant    <= w_grant;
          end
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_soc_network_adapter_fabric.sv
module tb_soc_network_adapter_fabric;
  localparam int FW  = 32;
  localparam int CH  = 2;
  localparam int MOD = 2;
  localparam int DEP = 4;

  logic                              clk;
  logic                              rst;
  logic [CH-1:0][FW-1:0]             noc_in_flit;
  logic [CH-1:0]                     noc_in_last;
  logic [CH-1:0]                     noc_in_valid;
  logic [CH-1:0]                     noc_in_ready;
  logic [CH-1:0][FW-1:0]             noc_out_flit;
  logic [CH-1:0]                     noc_out_last;
  logic [CH-1:0]                     noc_out_valid;
  logic [CH-1:0]                     noc_out_ready;
  logic [CH-1:0][MOD-1:0][FW-1:0]    mod_in_flit;
  logic [CH-1:0][MOD-1:0]            mod_in_last;
  logic [CH-1:0][MOD-1:0]            mod_in_valid;
  logic [CH-1:0][MOD-1:0]            mod_in_ready;
  logic [CH-1:0][MOD-1:0][FW-1:0]    mod_out_flit;
  logic [CH-1:0][MOD-1:0]            mod_out_last;
  logic [CH-1:0][MOD-1:0]            mod_out_valid;
  logic [CH-1:0][MOD-1:0]            mod_out_ready;
  logic [CH-1:0][15:0]               drop_count;
  logic                              drop_clear;

  soc_network_adapter_fabric #(
    .FLIT_WIDTH (FW),
    .CHANNELS   (CH),
    .MODULES    (MOD),
    .DEPTH      (DEP),
    .CLASS_LSB  (24),
    .CLASS_WIDTH(3),
    .MAPPING    (64'hFFFF_FFFF_FFFF_0100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .noc_in_flit  (noc_in_flit),
    .noc_in_last  (noc_in_last),
    .noc_in_valid (noc_in_valid),
    .noc_in_ready (noc_in_ready),
    .noc_out_flit (noc_out_flit),
    .noc_out_last (noc_out_last),
    .noc_out_valid(noc_out_valid),
    .noc_out_ready(noc_out_ready),
    .mod_in_flit  (mod_in_flit),
    .mod_in_last  (mod_in_last),
    .mod_in_valid (mod_in_valid),
    .mod_in_ready (mod_in_ready),
    .mod_out_flit (mod_out_flit),
    .mod_out_last (mod_out_last),
    .mod_out_valid(mod_out_valid),
    .mod_out_ready(mod_out_ready),
    .drop_count   (drop_count),
    .drop_clear   (drop_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] rf [3];
  logic [31:0] df [5];
  logic [4:0]  dl;
  int          seq [2];
  int          acc;
  logic [1:0]  rdy;
  logic [1:0]  vld;
  logic        rdy1;
  logic [31:0] got [$];

  initial begin
    rst           = 1'b1;
    noc_in_flit   = '0;
    noc_in_last   = '0;
    noc_in_valid  = '0;
    noc_out_ready = '1;
    mod_in_ready  = '1;
    mod_out_flit  = '0;
    mod_out_last  = '0;
    mod_out_valid = '0;
    drop_clear    = 1'b0;

    // ---- reset ----
    @(negedge clk); #1;
    chk("rst_noc_in_ready", 32'(noc_in_ready), 0);
    chk("rst_mod_out_ready", 32'(mod_out_ready), 0);
    chk("rst_noc_out_valid", 32'(noc_out_valid), 0);
    chk("rst_mod_in_valid", 32'(mod_in_valid), 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("init_drop_count", 32'(drop_count), 0);
    chk("init_noc_in_ready", 32'(noc_in_ready), 32'h3);
    $display("step reset done");

    // ---- routing: 3-flit class-1 packet on channel 0 ----
    rf[0] = 32'h0100_00A0; rf[1] = 32'h0000_00A1; rf[2] = 32'h0000_00A2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      noc_in_flit[0] = rf[k]; noc_in_last[0] = (k == 2); noc_in_valid[0] = 1'b1;
      #1;
      if (k > 0) begin
        chk("route_valid", 32'(mod_in_valid[0]), 32'h2);
        chk("route_flit", mod_in_flit[0][1], rf[k-1]);
      end
    end
    @(negedge clk); noc_in_valid[0] = 1'b0; #1;
    chk("route_valid_last", 32'(mod_in_valid[0]), 32'h2);
    chk("route_flit_last", mod_in_flit[0][1], rf[2]);
    chk("route_last_flag", 32'(mod_in_last[0][1]), 1);
    @(negedge clk); #1;
    chk("route_idle", 32'(mod_in_valid[0]), 0);
    $display("step routing class1 ch0 done");

    // ---- class 0 on channel 1 ----
    @(negedge clk);
    noc_in_flit[1] = 32'h0000_0055; noc_in_last[1] = 1'b1; noc_in_valid[1] = 1'b1;
    @(negedge clk); noc_in_valid[1] = 1'b0; #1;
    chk("ch1_route_valid", 32'(mod_in_valid[1]), 32'h1);
    chk("ch1_no_cross", 32'(mod_in_valid[0]), 0);
    @(negedge clk);
    $display("step routing class0 ch1 done");

    // ---- drop: 1-flit + 4-flit packets of class 5 ----
    df[0] = 32'h0500_0001; df[1] = 32'h0500_0002; df[2] = 32'h0100_0003;
    df[3] = 32'h0100_0004; df[4] = 32'h0100_0005; dl = 5'b10001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      noc_in_flit[0] = df[k]; noc_in_last[0] = dl[k]; noc_in_valid[0] = 1'b1;
      #1;
      chk("drop_ready", 32'(noc_in_ready[0]), 1);
      chk("drop_no_valid", 32'(mod_in_valid[0]), 0);
    end
    @(negedge clk); noc_in_valid[0] = 1'b0; #1;
    chk("drop_no_valid_tail", 32'(mod_in_valid[0]), 0);
    @(negedge clk); #1;
    chk("drop_count0", 32'(drop_count[0]), 2);
    chk("drop_count1", 32'(drop_count[1]), 0);
    $display("step drop two packets done");

    // third drop coincides with drop_clear
    @(negedge clk);
    noc_in_flit[0] = 32'h0500_0009; noc_in_last[0] = 1'b1; noc_in_valid[0] = 1'b1;
    @(negedge clk); noc_in_valid[0] = 1'b0; drop_clear = 1'b1;
    @(negedge clk); drop_clear = 1'b0; #1;
    chk("drop_clear_wins", 32'(drop_count[0]), 0);
    $display("step drop clear done");

    // ---- arbitration: M0 and M1 each send two 2-flit packets on ch0 ----
    seq[0] = 0; seq[1] = 0;
    got.delete();
    for (int cyc = 0; cyc < 30 && got.size() < 8; cyc++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        mod_out_valid[0][m] = (seq[m] < 4);
        mod_out_flit[0][m]  = {8'hC0, 8'(m), 16'(seq[m])};
        mod_out_last[0][m]  = (seq[m] % 2 == 1);
      end
      #1;
      if (noc_out_valid[0]) got.push_back(noc_out_flit[0]);
      rdy = mod_out_ready[0];
      vld = mod_out_valid[0];
      @(posedge clk);
      for (int m = 0; m < 2; m++) if (rdy[m] && vld[m]) seq[m]++;
    end
    @(negedge clk); mod_out_valid[0] = '0;
    chk("arb_count", 32'(got.size()), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      chk("arb_order", got[i], {8'hC0, 8'((i / 2) % 2), 16'((i / 4) * 2 + i % 2)});
    end
    $display("step arbitration done, %0d flits", got.size());

    // ---- back-pressure: 6-flit packet from M0 on ch1 with router stalled ----
    noc_out_ready[1] = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      mod_out_valid[1][0] = (acc < 6);
      mod_out_flit[1][0]  = 32'hB000_0000 + 32'(acc);
      mod_out_last[1][0]  = (acc == 5);
      #1;
      rdy1 = mod_out_ready[1][0];
      @(posedge clk);
      if (rdy1 && acc < 6) acc++;
    end
    @(negedge clk); #1;
    chk("bp_accepted", 32'(acc), 4);
    chk("bp_ready_low", 32'(mod_out_ready[1][0]), 0);
    chk("bp_head_valid", 32'(noc_out_valid[1]), 1);
    chk("bp_head_flit", noc_out_flit[1], 32'hB000_0000);
    noc_out_ready[1] = 1'b1;
    got.delete();
    for (int cyc = 0; cyc < 20 && got.size() < 6; cyc++) begin
      if (noc_out_valid[1]) got.push_back(noc_out_flit[1]);
      rdy1 = mod_out_ready[1][0];
      @(posedge clk);
      if (rdy1 && mod_out_valid[1][0]) acc++;
      @(negedge clk);
      mod_out_valid[1][0] = (acc < 6);
      mod_out_flit[1][0]  = 32'hB000_0000 + 32'(acc);
      mod_out_last[1][0]  = (acc == 5);
      #1;
    end
    mod_out_valid[1] = '0;
    chk("bp_total_accepted", 32'(acc), 6);
    chk("bp_emitted", 32'(got.size()), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      chk("bp_order", got[i], 32'hB000_0000 + 32'(i));
    end
    $display("step back-pressure done");

    // ---- saturation on channel 1 ----
    @(negedge clk);
    noc_in_flit[1] = 32'h0500_0000; noc_in_last[1] = 1'b1; noc_in_valid[1] = 1'b1;
    repeat (65000) @(posedge clk);
    @(negedge clk); noc_in_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("sat_partial", 32'(drop_count[1]), 65000);
    @(negedge clk); noc_in_valid[1] = 1'b1;
    repeat (537) @(posedge clk);
    @(negedge clk); noc_in_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("sat_hold", 32'(drop_count[1]), 32'hFFFF);
    $display("step saturation done");

    // ---- reset mid-packet ----
    noc_out_ready[0] = 1'b0;
    @(negedge clk);
    noc_in_flit[0] = 32'h0100_0100; noc_in_last[0] = 1'b0; noc_in_valid[0] = 1'b1;
    mod_out_valid[0] = 2'b10; mod_out_flit[0][1] = 32'hE100_0000; mod_out_last[0][1] = 1'b0;
    @(negedge clk);
    noc_in_flit[0] = 32'h0000_0101;
    mod_out_valid[0] = '0;
    @(negedge clk);
    noc_in_valid[0] = 1'b0; #1;
    chk("pre_rst_out_valid", 32'(noc_out_valid[0]), 1);
    chk("pre_rst_in_valid", 32'(mod_in_valid[0]), 32'h2);
    rst = 1'b1; #1;
    chk("mid_rst_in_ready", 32'(noc_in_ready), 0);
    chk("mid_rst_mod_in_valid", 32'(mod_in_valid), 0);
    chk("mid_rst_out_valid", 32'(noc_out_valid), 0);
    chk("mid_rst_mod_out_ready", 32'(mod_out_ready), 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_drop_count", 32'(drop_count), 0);
    chk("post_rst_out_valid", 32'(noc_out_valid), 0);
    chk("post_rst_mod_in_valid", 32'(mod_in_valid), 0);
    noc_in_flit[0] = 32'h0000_0200; noc_in_last[0] = 1'b1; noc_in_valid[0] = 1'b1;
    mod_out_valid[0] = 2'b01; mod_out_flit[0][0] = 32'hE000_0001; mod_out_last[0][0] = 1'b1;
    #1;
    chk("post_rst_grant", 32'(mod_out_ready[0]), 32'h1);
    @(negedge clk);
    noc_in_valid[0] = 1'b0; mod_out_valid[0] = '0; #1;
    chk("post_rst_header_route", 32'(mod_in_valid[0]), 32'h1);
    chk("post_rst_header_flit", mod_in_flit[0][0], 32'h0000_0200);
    chk("post_rst_egress_valid", 32'(noc_out_valid[0]), 1);
    chk("post_rst_egress_flit", noc_out_flit[0], 32'hE000_0001);
    noc_out_ready[0] = 1'b1;
    $display("step reset mid-packet done");

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
